// File: rtl/nv_mux2_arb_pkg.sv
// nv_mux2_arb_pkg
//   Shared definitions for the two-source merge arbiter:
//   - arb_state_e : arbitration state (IDLE, LOCK0, LOCK1)
//   - SRC0 / SRC1 : source index values carried on mux_sel
package nv_mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/MUX2HDD2.sv
// MUX2HDD2
//   Behavioural model of the 2:1 mux standard cell used in the datapath bank.
//   I0 : selected when S=0
//   I1 : selected when S=1
//   S  : select
//   Z  : output
module MUX2HDD2 (
    input  logic I0,
    input  logic I1,
    input  logic S,
    output logic Z
);

    assign Z = S ? I1 : I0;

endmodule

// File: rtl/nv_mux2_arb_pipe.sv
// nv_mux2_arb_pipe
//   One-entry valid/ready output register.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push       : load i_data this cycle (caller only pushes when o_pipe_rdy)
//   i_data       : data to load
//   i_ready      : downstream accept
//   o_valid      : register holds a beat
//   o_data       : registered data, stable while o_valid && !i_ready
//   o_pipe_rdy   : register can take a beat this cycle (empty or draining)
module nv_mux2_arb_pipe #(
    parameter int unsigned W = 33
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_pipe_rdy
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_pipe_rdy = !r_valid || i_ready;
    assign o_valid    = r_valid;
    assign o_data     = r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_push) begin
            // a push while draining replaces the beat with no bubble
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nv_mux2_arb.sv
// nv_mux2_arb
//   Round-robin valid/ready arbiter merging two sources onto one port through
//   a MUX2HDD2 datapath bank, with optional packet lock on `last`, followed by
//   a one-stage registered output.
//   nvdla_core_clk/rst : clock, asynchronous active-high reset
//   srcN_valid/ready/pd/last : source N beat handshake, payload, end-of-packet
//   dst_valid/ready/pd/last  : registered output handshake and beat
//   mux_sel            : datapath select (0 = src0, 1 = src1)
module nv_mux2_arb
    import nv_mux2_arb_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter bit          LOCK_EN = 1'b1
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    input  logic          src0_valid,
    output logic          src0_ready,
    input  logic [DW-1:0] src0_pd,
    input  logic          src0_last,
    input  logic          src1_valid,
    output logic          src1_ready,
    input  logic [DW-1:0] src1_pd,
    input  logic          src1_last,
    output logic          dst_valid,
    input  logic          dst_ready,
    output logic [DW-1:0] dst_pd,
    output logic          dst_last,
    output logic          mux_sel
);

    arb_state_e  r_state;
    logic        r_prio;
    logic        r_sel;

    logic        w_gnt_vld;
    logic        w_gnt;
    logic        w_pipe_rdy;
    logic        w_acc;
    logic [DW:0] w_in0;
    logic [DW:0] w_in1;
    logic [DW:0] w_mux;
    logic [DW:0] w_dst;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = SRC0;
        case (r_state)
            IDLE: begin
                if (src0_valid && src1_valid) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = r_prio;
                end else if (src0_valid) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = SRC0;
                end else if (src1_valid) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = SRC1;
                end
            end
            // a locked owner keeps the grant even while it is not valid
            LOCK0: begin
                w_gnt_vld = 1'b1;
                w_gnt     = SRC0;
            end
            LOCK1: begin
                w_gnt_vld = 1'b1;
                w_gnt     = SRC1;
            end
            default: ;
        endcase
        if (nvdla_core_rst) begin
            w_gnt_vld = 1'b0;
        end
    end

    // with no grant the select parks on the last granted source
    assign mux_sel    = w_gnt_vld ? w_gnt : r_sel;
    assign src0_ready = w_pipe_rdy && w_gnt_vld && (w_gnt == SRC0);
    assign src1_ready = w_pipe_rdy && w_gnt_vld && (w_gnt == SRC1);
    assign w_acc      = (src0_valid && src0_ready) || (src1_valid && src1_ready);

    assign w_in0 = {src0_last, src0_pd};
    assign w_in1 = {src1_last, src1_pd};

    for (genvar i = 0; i < DW + 1; i++) begin : g_mux
        MUX2HDD2 u_mux (
            .I0 (w_in0[i]),
            .I1 (w_in1[i]),
            .S  (mux_sel),
            .Z  (w_mux[i])
        );
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_state <= IDLE;
            r_prio  <= SRC0;
            r_sel   <= SRC0;
        end else begin
            r_sel <= mux_sel;
            if (w_acc) begin
                if (LOCK_EN) begin
                    if (w_mux[DW]) begin
                        r_state <= IDLE;
                        r_prio  <= ~w_gnt;
                    end else begin
                        r_state <= (w_gnt == SRC1) ? LOCK1 : LOCK0;
                    end
                end else begin
                    r_prio <= ~w_gnt;
                end
            end
        end
    end

    nv_mux2_arb_pipe #(
        .W (DW + 1)
    ) u_pipe (
        .i_clk      (nvdla_core_clk),
        .i_rst      (nvdla_core_rst),
        .i_push     (w_acc),
        .i_data     (w_mux),
        .i_ready    (dst_ready),
        .o_valid    (dst_valid),
        .o_data     (w_dst),
        .o_pipe_rdy (w_pipe_rdy)
    );

    assign dst_last = w_dst[DW];
    assign dst_pd   = w_dst[DW-1:0];

endmodule

// File: tb/tb_nv_mux2_arb.sv
// tb_nv_mux2_arb
//   Two arbiters (packet lock on / off) driven by the same stimulus and
//   checked every cycle against a behavioural model, plus a directed vector
//   table and hand-written corner-case sequences.
module tb_nv_mux2_arb;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic v0, v1, l0, l1, dr;
    logic [DW-1:0] pd0, pd1;

    logic s0r [2];
    logic s1r [2];
    logic dv  [2];
    logic dl  [2];
    logic sel [2];
    logic [DW-1:0] dpd [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nv_mux2_arb #(.DW(DW), .LOCK_EN(1'b1)) u_lock (
        .nvdla_core_clk (clk), .nvdla_core_rst (rst),
        .src0_valid (v0), .src0_ready (s0r[0]), .src0_pd (pd0), .src0_last (l0),
        .src1_valid (v1), .src1_ready (s1r[0]), .src1_pd (pd1), .src1_last (l1),
        .dst_valid (dv[0]), .dst_ready (dr), .dst_pd (dpd[0]), .dst_last (dl[0]),
        .mux_sel (sel[0])
    );

    nv_mux2_arb #(.DW(DW), .LOCK_EN(1'b0)) u_nolock (
        .nvdla_core_clk (clk), .nvdla_core_rst (rst),
        .src0_valid (v0), .src0_ready (s0r[1]), .src0_pd (pd0), .src0_last (l0),
        .src1_valid (v1), .src1_ready (s1r[1]), .src1_pd (pd1), .src1_last (l1),
        .dst_valid (dv[1]), .dst_ready (dr), .dst_pd (dpd[1]), .dst_last (dl[1]),
        .mux_sel (sel[1])
    );

    // reference model: index 0 locks packets, index 1 arbitrates per beat
    int            m_own  [2];   // -1 = no packet owner, else owning source
    int            m_prio [2];
    int            m_sel  [2];
    bit            m_dv   [2];
    bit            m_dl   [2];
    logic [DW-1:0] m_dpd  [2];
    int            e_r0   [2];
    int            e_r1   [2];
    int            e_sel  [2];
    int            e_g    [2];
    bit            e_acc  [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_own[k] = -1; m_prio[k] = 0; m_sel[k] = 0;
        m_dv[k] = 1'b0; m_dl[k] = 1'b0; m_dpd[k] = '0;
    endtask

    task automatic model_eval(input int k);
        bit prdy, gv;
        int g;
        prdy = !m_dv[k] || dr;
        gv = 1'b0; g = 0;
        if (!rst) begin
            if (m_own[k] >= 0) begin gv = 1'b1; g = m_own[k]; end
            else if (v0 && v1) begin gv = 1'b1; g = m_prio[k]; end
            else if (v0)       begin gv = 1'b1; g = 0; end
            else if (v1)       begin gv = 1'b1; g = 1; end
        end
        e_g[k]   = g;
        e_sel[k] = gv ? g : m_sel[k];
        e_r0[k]  = (prdy && gv && g == 0) ? 1 : 0;
        e_r1[k]  = (prdy && gv && g == 1) ? 1 : 0;
        e_acc[k] = gv && prdy && ((g == 1) ? v1 : v0);
    endtask

    task automatic model_update(input int k);
        bit last;
        int g;
        if (rst) begin
            model_reset(k);
        end else begin
            g = e_g[k];
            m_sel[k] = e_sel[k];
            if (e_acc[k]) begin
                last     = (g == 1) ? l1 : l0;
                m_dv[k]  = 1'b1;
                m_dpd[k] = (g == 1) ? pd1 : pd0;
                m_dl[k]  = last;
                if (k == 0) begin
                    if (last) begin m_own[k] = -1; m_prio[k] = 1 - g; end
                    else m_own[k] = g;
                end else begin
                    m_prio[k] = 1 - g;
                end
            end else if (dr) begin
                m_dv[k] = 1'b0;
            end
        end
    endtask

    // compare all outputs of both DUTs with the model on the falling edge
    task automatic check_phase();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) model_reset(k);
            model_eval(k);
            chk($sformatf("u%0d src0_ready", k), s0r[k], e_r0[k]);
            chk($sformatf("u%0d src1_ready", k), s1r[k], e_r1[k]);
            chk($sformatf("u%0d mux_sel", k),    sel[k], e_sel[k]);
            chk($sformatf("u%0d dst_valid", k),  dv[k],  m_dv[k]);
            chk($sformatf("u%0d dst_pd", k),     dpd[k], m_dpd[k]);
            chk($sformatf("u%0d dst_last", k),   dl[k],  m_dl[k]);
        end
    endtask

    task automatic clock_phase();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        #1;
    endtask

    task automatic step();
        check_phase();
        clock_phase();
    endtask

    typedef struct {
        bit v0, v1, l0, l1, dr;
        logic [DW-1:0] pd0, pd1;
        bit e_r0, e_r1, e_sel, e_nsel;
        logic [DW-1:0] e_dpd;
    } vec_t;

    vec_t tbl [9];

    initial begin
        // contention (rows 0-3), lone src0 beat (4), locked src1 packet (5-7),
        // src0 granted after the packet (8); e_nsel is the no-lock select
        tbl[0] = '{1,1,1,1,1, 32'hA0, 32'hB0, 1,0,0,0, 32'hA0};
        tbl[1] = '{1,1,1,1,1, 32'hA1, 32'hB1, 0,1,1,1, 32'hB1};
        tbl[2] = '{1,1,1,1,1, 32'hA2, 32'hB2, 1,0,0,0, 32'hA2};
        tbl[3] = '{1,1,1,1,1, 32'hA3, 32'hB3, 0,1,1,1, 32'hB3};
        tbl[4] = '{1,0,1,1,1, 32'hA4, 32'hB4, 1,0,0,0, 32'hA4};
        tbl[5] = '{1,1,1,0,1, 32'hA5, 32'hB5, 0,1,1,1, 32'hB5};
        tbl[6] = '{1,1,1,0,1, 32'hA6, 32'hB6, 0,1,1,0, 32'hB6};
        tbl[7] = '{1,1,1,1,1, 32'hA7, 32'hB7, 0,1,1,1, 32'hB7};
        tbl[8] = '{1,1,1,1,1, 32'hA8, 32'hB8, 1,0,0,0, 32'hA8};

        rst = 1'b1; v0 = 0; v1 = 0; l0 = 0; l1 = 0; dr = 1'b1; pd0 = '0; pd1 = '0;
        model_reset(0); model_reset(1);
        step();
        chk("reset dst_valid", dv[0], 1'b0);
        chk("reset mux_sel", sel[0], 1'b0);
        step();
        rst = 1'b0;

        foreach (tbl[i]) begin
            v0 = tbl[i].v0; v1 = tbl[i].v1; l0 = tbl[i].l0; l1 = tbl[i].l1;
            dr = tbl[i].dr; pd0 = tbl[i].pd0; pd1 = tbl[i].pd1;
            check_phase();
            chk($sformatf("vec%0d src0_ready", i), s0r[0], tbl[i].e_r0);
            chk($sformatf("vec%0d src1_ready", i), s1r[0], tbl[i].e_r1);
            chk($sformatf("vec%0d mux_sel", i),    sel[0], tbl[i].e_sel);
            chk($sformatf("vec%0d nolock mux_sel", i), sel[1], tbl[i].e_nsel);
            clock_phase();
            chk($sformatf("vec%0d dst_valid", i), dv[0], 1'b1);
            chk($sformatf("vec%0d dst_pd", i), dpd[0], tbl[i].e_dpd);
        end

        // backpressure: held beat A8 must not move, nobody is ready
        v0 = 1; v1 = 1; l0 = 1; l1 = 1; pd0 = 32'hC0; pd1 = 32'hD0; dr = 0;
        for (int c = 0; c < 5; c++) begin
            check_phase();
            chk("bp src0_ready", s0r[0], 1'b0);
            chk("bp src1_ready", s1r[0], 1'b0);
            chk("bp dst_pd", dpd[0], 32'hA8);
            clock_phase();
        end
        dr = 1;
        check_phase();
        chk("bp release src1_ready", s1r[0], 1'b1);
        clock_phase();
        chk("bp release dst_valid", dv[0], 1'b1);
        chk("bp release dst_pd", dpd[0], 32'hD0);

        // mid-packet reset: prio moved to src1, src1 packet locked, then reset
        v0 = 1; v1 = 0; l0 = 1; pd0 = 32'hE0;
        step();
        v0 = 0; v1 = 1; l1 = 0; pd1 = 32'hF0;
        step();
        rst = 1'b1;
        #1;
        chk("rst async dst_valid", dv[0], 1'b0);
        chk("rst src1_ready", s1r[0], 1'b0);
        step();
        rst = 1'b0;
        v0 = 1; v1 = 1; l0 = 1; l1 = 0; pd0 = 32'hE1; pd1 = 32'hF1;
        check_phase();
        chk("post-rst mux_sel", sel[0], 1'b0);
        chk("post-rst src0_ready", s0r[0], 1'b1);
        chk("post-rst src1_ready", s1r[0], 1'b0);
        clock_phase();
        chk("post-rst dst_pd", dpd[0], 32'hE1);

        // idle select hold after a lone src1 beat
        v0 = 0; v1 = 1; l1 = 1; pd1 = 32'h5A;
        step();
        v1 = 0;
        check_phase();
        chk("idle mux_sel", sel[0], 1'b1);
        clock_phase();
        chk("idle dst_valid drop", dv[0], 1'b0);
        check_phase();
        chk("idle mux_sel hold", sel[0], 1'b1);
        clock_phase();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            l0 = 1'($urandom_range(0, 2) == 0);
            l1 = 1'($urandom_range(0, 2) == 0);
            dr = 1'($urandom_range(0, 3) != 0);
            pd0 = $urandom;
            pd1 = $urandom;
            rst = 1'($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nv_mux2_arb.md
# nv_mux2_arb

Two-source valid/ready arbiter that shares one 2:1 datapath select (a per-bit bank of MUX2HDD2 cells) between two requesters. It applies round-robin fairness with optional packet lock on a `last` flag, and drives the select. The selected beat goes into a one-stage registered output pipe. It sits wherever two NVDLA sub-unit streams merge onto one downstream port, for example read-return merge or DMA request merge.

## Interface
Parameters:
- DW, 32: payload width in bits.
- LOCK_EN, 1: when 1, a grant is held from the first beat of a packet until its `last` beat; when 0, arbitration happens on every beat.

Ports:
- nvdla_core_clk, in, 1: clock.
- nvdla_core_rst, in, 1: reset. One clock; reset is asynchronous and active-high.
- src0_valid, in, 1: source 0 beat valid.
- src0_ready, out, 1: source 0 beat accepted this cycle.
- src0_pd, in, DW: source 0 payload.
- src0_last, in, 1: source 0 end-of-packet.
- src1_valid / src1_ready / src1_pd / src1_last: same as source 0, for source 1.
- dst_valid, out, 1: registered output valid.
- dst_ready, in, 1: downstream accept.
- dst_pd, out, DW: registered payload.
- dst_last, out, 1: registered end-of-packet.
- mux_sel, out, 1: current datapath select, 0 = src0, 1 = src1.

## Operation
- States:
  - IDLE: no packet in flight.
  - LOCK0: src0 holds the datapath.
  - LOCK1: src1 holds the datapath.
- Register `prio` names the source that wins the next tie. Reset value: src0 wins first.
- Grant rules:
  - IDLE, exactly one valid: that source is granted.
  - IDLE, both valid: the `prio` source is granted.
  - IDLE, none valid: no grant; mux_sel holds its previous value.
  - LOCKn: only source n is granted, even if n is not valid. The other source always sees ready=0.
- Beat acceptance: `pipe_rdy = !dst_valid || dst_ready`. Then `srcN_ready = pipe_rdy && grantN`. A beat is accepted when `srcN_valid && srcN_ready`.
- State transitions, taken only on an accepted beat from source n:
  - IDLE → LOCKn when LOCK_EN=1 and last=0.
  - IDLE stays IDLE when last=1 or LOCK_EN=0.
  - LOCKn → IDLE when last=1.
  - LOCKn stays LOCKn when last=0.
- `prio` update: on an accepted beat with last=1 (or any accepted beat when LOCK_EN=0), `prio` becomes the other source.
- mux_sel equals the granted source index. The payload and last bits of the granted source pass through the MUX2HDD2 bank, driven by mux_sel.
- Output pipe: on an accepted beat, dst_pd/dst_last are loaded from the mux output and dst_valid becomes 1. If `dst_valid && dst_ready` and no beat is accepted, dst_valid clears. dst_pd/dst_last hold their value while dst_valid=1 and dst_ready=0.
- Sources are required to hold valid and payload stable until ready. The arbiter does not check this.

## Timing
- Reset values: dst_valid=0, dst_pd=0, dst_last=0, mux_sel=0, state=IDLE, prio=src0. src0_ready/src1_ready are 0 while reset is asserted.
- Latency: a beat accepted in cycle T appears on dst in cycle T+1.
- Throughput: one beat per cycle while dst_ready=1.
- srcN_ready is combinational from dst_valid, dst_ready, state, prio and the src valids. There is no path from srcN_pd to ready.
- Simultaneous pop and push: when `dst_valid && dst_ready` and a beat is accepted in the same cycle, dst_valid stays 1 and the register loads the new beat.
- Reset asserted mid-packet: state returns to IDLE immediately (asynchronous), the pipe is flushed, and the partial packet is lost. Discarding the partial packet is the upstream's responsibility.
- Single-beat packet (last=1 on the first beat): the state never leaves IDLE and `prio` toggles.

## Structure
- Shared package nv_mux2_arb_pkg: state encoding constants (IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2) and source-index constants SRC0=1'b0, SRC1=1'b1.
- Sub-module nv_mux2_arb_pipe: the one-entry valid/ready output register, parameterised on width DW+1 (payload plus last).
- Data mux: generate loop of DW+1 MUX2HDD2 instances with S=mux_sel.

## Test plan
- Contention after reset: both valid, single-beat packets, dst_ready=1 → dst order src0, src1, src0, src1; mux_sel toggles 0,1,0,1.
- Packet lock, LOCK_EN=1: src1 sends a 3-beat packet (last on beat 3) while src0 is valid throughout → src0_ready=0 for all 3 cycles, then src0 is granted in cycle 4.
- Per-beat arbitration, LOCK_EN=0, same stimulus → dst alternates src1, src0 per beat.
- Backpressure: dst_ready=0 for 5 cycles with dst_valid=1 → both readies are 0 and dst_pd is stable. Release → the next beat loads in the same cycle the held beat drains; no bubble.
- Mid-packet reset: assert nvdla_core_rst after beat 1 of a 4-beat src1 packet → dst_valid=0 immediately. After release, a src0 single beat is granted first.
- Idle select hold: src1 sends one beat, then no valids → mux_sel stays 1 and dst_valid drops after one cycle with dst_ready=1.
